// File: rtl/dmem_dma_copy.sv
// dmem_dma_copy: word-by-word block copy engine on the shared data-memory port.
// Each word takes one READ cycle (capture into buf) and one WRITE cycle; any
// cycle without grant simply repeats the current step. mem_we is gated by clrn
// so that a reset cycle can never commit a write.
module dmem_dma_copy #(
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             clrn,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_datain,
  output logic             mem_we,
  input  logic [31:0]      mem_dataout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      src_ptr_q <= 32'd0;
      dst_ptr_q <= 32'd0;
      cnt_q     <= CNT_ZERO;
      buf_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state and datapath update; every step only advances under grant.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            src_ptr_d = {src[31:2], 2'b00};
            dst_ptr_d = {dst[31:2], 2'b00};
            cnt_d     = len;
            state_d   = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (bus_gnt) begin
          buf_d   = mem_dataout;
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (bus_gnt) begin
          src_ptr_d = src_ptr_q + 32'd4;
          dst_ptr_d = dst_ptr_q + 32'd4;
          cnt_d     = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register; mem_we additionally gated by grant and reset.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    mem_addr   = 32'd0;
    mem_datain = 32'd0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_READ: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        mem_addr = src_ptr_q;
      end
      S_WRITE: begin
        busy       = 1'b1;
        bus_req    = 1'b1;
        mem_addr   = dst_ptr_q;
        mem_datain = buf_q;
        mem_we     = bus_gnt & clrn;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
